wb_spi_master: RTL

- Wishbone-slave to SPI-master bridge; the initiator end of the SPI register-access link.
- Turns each Wishbone single read or write into one SPI frame toward an SPI-slave bridge.
- Frame: command byte, 24-bit word address, then 32-bit data.
- Sits on the host-side fabric, so an FPGA/SoC can read and write a remote Wishbone space over four wires.

---
 rtl/wb_spi_master_if.sv | 13 +
 rtl/wb_spi_master.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_master_if.sv
// Wishbone single-access bus between a host master and the SPI bridge.
interface wb_spi_master_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [25:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;

    modport master (output cyc, stb, we, adr, wdat, input ack, rdat);
    modport slave  (input cyc, stb, we, adr, wdat, output ack, rdat);
endinterface

// File: rtl/wb_spi_master.sv
// Wishbone-slave to SPI-master bridge: one Wishbone access becomes one mode-0 SPI frame.
// Optional inter-frame chip-select gap enabled by defining WB_SPI_MASTER_CS_GAP_EN.
module wb_spi_master #(
    parameter int CLK_DIV    = 2,
    parameter int DUMMY_BITS = 8,
    parameter int CS_GAP     = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_spi_master_if.slave wb,
    output logic           sck,
    output logic           ssn,
    output logic           mosi,
    input  logic           miso,
    output logic           busy
);

    localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
    localparam logic [6:0] N_WRITE  = 7'd64;
    localparam logic [6:0] N_READ   = 7'(64 + DUMMY_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        HOLD,
        DONE
`ifdef WB_SPI_MASTER_CS_GAP_EN
        , GAP
`endif
    } state_t;

    state_t      state_reg;
    logic [7:0]  div_cnt_reg;
    logic [6:0]  bit_cnt_reg;
    logic [63:0] tx_sr_reg;
    logic [31:0] rx_sr_reg;
    logic        is_read_reg;
    logic        abort_reg;
    logic        sck_reg;
    logic        ssn_reg;
    logic        mosi_reg;
    logic        busy_reg;
    logic        ack_reg;
    logic [31:0] rdat_reg;
`ifdef WB_SPI_MASTER_CS_GAP_EN
    logic [7:0]  gap_cnt_reg;
`else
    logic        cs_gap_unused;
    assign cs_gap_unused = (CS_GAP > 0);
`endif

    logic [63:0] load_word;
    logic        capture;
    logic        adr_lsb_unused;

    assign load_word = {wb.we ? 8'h02 : 8'h03, wb.adr[25:2], wb.we ? wb.wdat : 32'h0};
    // bit_cnt holds the bits still to go, so the final 32 of a read are the data bits
    assign capture        = is_read_reg && (bit_cnt_reg <= 7'd32);
    assign adr_lsb_unused = ^wb.adr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            tx_sr_reg   <= '0;
            rx_sr_reg   <= '0;
            is_read_reg <= 1'b0;
            abort_reg   <= 1'b0;
            sck_reg     <= 1'b0;
            ssn_reg     <= 1'b1;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            rdat_reg    <= '0;
`ifdef WB_SPI_MASTER_CS_GAP_EN
            gap_cnt_reg <= '0;
`endif
        end else begin
            ack_reg <= 1'b0;
            if (state_reg != IDLE && !wb.cyc)
                abort_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (wb.cyc && wb.stb) begin
                        state_reg   <= SETUP;
                        div_cnt_reg <= DIV_LOAD;
                        bit_cnt_reg <= wb.we ? N_WRITE : N_READ;
                        tx_sr_reg   <= load_word;
                        mosi_reg    <= load_word[63];
                        is_read_reg <= !wb.we;
                        abort_reg   <= 1'b0;
                        ssn_reg     <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                SETUP: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg   <= SCK_HI;
                        div_cnt_reg <= DIV_LOAD;
                        sck_reg     <= 1'b1;
                        if (capture)
                            rx_sr_reg <= {rx_sr_reg[30:0], miso};
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end
                SCK_HI: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg   <= SCK_LO;
                        div_cnt_reg <= DIV_LOAD;
                        sck_reg     <= 1'b0;
                        tx_sr_reg   <= {tx_sr_reg[62:0], 1'b0};
                        mosi_reg    <= tx_sr_reg[62];
                        bit_cnt_reg <= bit_cnt_reg - 7'd1;
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end
                SCK_LO: begin
                    if (div_cnt_reg == 8'd0) begin
                        div_cnt_reg <= DIV_LOAD;
                        if (bit_cnt_reg == 7'd0) begin
                            state_reg <= HOLD;
                        end else begin
                            state_reg <= SCK_HI;
                            sck_reg   <= 1'b1;
                            if (capture)
                                rx_sr_reg <= {rx_sr_reg[30:0], miso};
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end
                HOLD: begin
                    if (div_cnt_reg == 8'd0) begin
                        state_reg <= DONE;
                        ssn_reg   <= 1'b1;
                        // an abandoned cycle still finishes on the wire but is never acked
                        ack_reg   <= !abort_reg && wb.cyc;
                        if (is_read_reg)
                            rdat_reg <= rx_sr_reg;
                    end else begin
                        div_cnt_reg <= div_cnt_reg - 8'd1;
                    end
                end
                DONE: begin
`ifdef WB_SPI_MASTER_CS_GAP_EN
                    state_reg   <= GAP;
                    gap_cnt_reg <= 8'(CS_GAP - 1);
`else
                    state_reg   <= IDLE;
                    busy_reg    <= 1'b0;
`endif
                end
`ifdef WB_SPI_MASTER_CS_GAP_EN
                GAP: begin
                    if (gap_cnt_reg == 8'd0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 8'd1;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sck     = sck_reg;
    assign ssn     = ssn_reg;
    assign mosi    = mosi_reg;
    assign busy    = busy_reg;
    assign wb.ack  = ack_reg;
    assign wb.rdat = rdat_reg;

endmodule
